// File: rtl/seg_display_sched.sv
// Round-robin scheduler sharing a two-digit seven-segment display between NREQ requesters,
// plus the 1 ms multiplex strobe. Define SEG_SCHED_PRIORITY_EN to make requester 0 pre-empt.
module seg_display_sched #(
  parameter int         CLK_HZ  = 12000000,
  parameter int         NREQ    = 4,
  parameter int         HOLD_MS = 250,
  parameter int         MAX_MS  = 2000,
  parameter logic [3:0] IDLE_LO = 4'h0,
  parameter logic [3:0] IDLE_HI = 4'h0
) (
  input  logic              refclk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_lo,
  input  logic [4*NREQ-1:0] req_hi,
  output logic [NREQ-1:0]   gnt,
  output logic              mSFlag,
  output logic [3:0]        loValue,
  output logic [3:0]        hiValue,
  output logic              busy
);
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int IDX_W    = $clog2(NREQ);
  localparam int CNT_W    = $clog2(MAX_MS + 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q;
  logic [IDX_W-1:0]  owner_q, owner_d, winner;
  logic [CNT_W-1:0]  hold_q, hold_d, own_q, own_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, owner_oh, cand;
  logic [3:0]        lo_q, lo_d, hi_q, hi_d;
  logic              owner_req, any_cand, release_now, grant_now;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = IDX_W'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  // Free-running ms tick, independent of the scheduler state
  always_ff @(posedge refclk) begin
    if (!resetn) tick_q <= '0;
    else if (tick_q == TICK_W'(TICK_DIV - 1)) tick_q <= '0;
    else tick_q <= tick_q + TICK_W'(1);
  end

  assign mSFlag = (tick_q == TICK_W'(TICK_DIV - 1));

  // While owning, the current owner is excluded so a release hands over to someone else
  always_comb begin
    owner_oh  = onehot(owner_q);
    owner_req = |(req & owner_oh);
    cand      = (state_q == S_OWN) ? (req & ~owner_oh) : req;
    any_cand  = |cand;
    winner    = rr_pick(cand, owner_q);
    release_now = (state_q == S_OWN) && (hold_q == '0) &&
                  (!owner_req || ((own_q >= CNT_W'(MAX_MS)) && any_cand));
`ifdef SEG_SCHED_PRIORITY_EN
    if (cand[0]) winner = '0;
    if ((state_q == S_OWN) && req[0] && (owner_q != '0)) release_now = 1'b1;
`endif
    grant_now = any_cand && ((state_q == S_IDLE) || release_now);
  end

  always_ff @(posedge refclk) begin
    if (!resetn) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_cand) state_d = S_OWN;
      S_OWN:   if (release_now && !any_cand) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    own_d   = own_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (state_q == S_IDLE) begin
      gnt_d = '0;
      lo_d  = IDLE_LO;
      hi_d  = IDLE_HI;
    end else begin
      if (owner_req) begin
        lo_d = req_lo[4*int'(owner_q) +: 4];
        hi_d = req_hi[4*int'(owner_q) +: 4];
      end
      if (mSFlag) begin
        hold_d = (hold_q == '0) ? hold_q : hold_q - CNT_W'(1);
        own_d  = (own_q >= CNT_W'(MAX_MS)) ? own_q : own_q + CNT_W'(1);
      end
      if (release_now && !any_cand) begin
        gnt_d = '0;
        lo_d  = IDLE_LO;
        hi_d  = IDLE_HI;
      end
    end
    if (grant_now) begin
      gnt_d   = onehot(winner);
      owner_d = winner;
      hold_d  = CNT_W'(HOLD_MS);
      own_d   = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (!resetn) begin
      gnt_q   <= '0;
      owner_q <= IDX_W'(NREQ - 1);
      hold_q  <= '0;
      own_q   <= '0;
      lo_q    <= IDLE_LO;
      hi_q    <= IDLE_HI;
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      own_q   <= own_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign gnt     = gnt_q;
  assign loValue = lo_q;
  assign hiValue = hi_q;
  assign busy    = (state_q == S_OWN);
endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with TICK_DIV=10, NREQ=4, HOLD_MS=3, MAX_MS=6.
module tb_seg_display_sched;
  logic        refclk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] req_lo, req_hi;
  logic [3:0]  gnt;
  logic        mSFlag;
  logic [3:0]  loValue, hiValue;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  seg_display_sched #(
    .CLK_HZ(10000), .NREQ(4), .HOLD_MS(3), .MAX_MS(6), .IDLE_LO(4'h0), .IDLE_HI(4'h0)
  ) dut (
    .refclk(refclk), .resetn(resetn), .req(req), .req_lo(req_lo), .req_hi(req_hi),
    .gnt(gnt), .mSFlag(mSFlag), .loValue(loValue), .hiValue(hiValue), .busy(busy)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic        rstn;
    logic [3:0]  req;
    logic [15:0] lo;
    logic [15:0] hi;
    int          n;
    logic [3:0]  e_gnt;
    logic [3:0]  e_lo;
    logic [3:0]  e_hi;
    logic        e_busy;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_vec(input int i);
    resetn = tbl[i].rstn;
    req    = tbl[i].req;
    req_lo = tbl[i].lo;
    req_hi = tbl[i].hi;
    repeat (tbl[i].n) step();
    chk($sformatf("v%0d_gnt", i), 16'(gnt), 16'(tbl[i].e_gnt));
    chk($sformatf("v%0d_lo", i), 16'(loValue), 16'(tbl[i].e_lo));
    chk($sformatf("v%0d_hi", i), 16'(hiValue), 16'(tbl[i].e_hi));
    chk($sformatf("v%0d_busy", i), 16'(busy), 16'(tbl[i].e_busy));
  endtask

  initial begin
    // reset, then single requester 1 grant / drop / hold expiry (starting at tick phase 0)
    tbl[0] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 2,  4'b0000, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 4'b0010, 16'h0050, 16'h00A0, 1,  4'b0010, 4'h0, 4'h0, 1'b1};
    tbl[2] = '{1'b1, 4'b0010, 16'h0050, 16'h00A0, 1,  4'b0010, 4'h5, 4'hA, 1'b1};
    tbl[3] = '{1'b1, 4'b0000, 16'h0070, 16'h0010, 27, 4'b0010, 4'h5, 4'hA, 1'b1};
    tbl[4] = '{1'b1, 4'b0000, 16'h0070, 16'h0010, 1,  4'b0010, 4'h5, 4'hA, 1'b1};
    tbl[5] = '{1'b1, 4'b0000, 16'h0070, 16'h0010, 1,  4'b0000, 4'h0, 4'h0, 1'b0};

    resetn = 1'b0; req = '0; req_lo = '0; req_hi = '0;
    apply_vec(0);
    chk("rst_msflag", 16'(mSFlag), 16'h0);

    // Idle: strobe every 10 cycles, first when tick reaches 9
    resetn = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      step();
      chk($sformatf("msflag_t%0d", t), 16'(mSFlag), ((t % 10) == 9) ? 16'h1 : 16'h0);
    end
    chk("idle_gnt", 16'(gnt), 16'h0);
    chk("idle_busy", 16'(busy), 16'h0);

    for (int i = 1; i < 6; i++) apply_vec(i);

    // All four requesting: 60-cycle ownerships rotating 0,1,2,3 from a fresh reset
    resetn = 1'b0;
    step();
    resetn = 1'b1; req = 4'b1111; req_lo = 16'h3210; req_hi = 16'hDCBA;
    for (int t = 1; t <= 130; t++) begin
      int k;
      step();
      k = ((t - 1) / 60) % 4;
`ifndef SEG_SCHED_PRIORITY_EN
      chk($sformatf("rot_gnt_t%0d", t), 16'(gnt), 16'(4'b0001 << k));
      chk($sformatf("rot_onehot_t%0d", t), 16'($countones(gnt) <= 1), 16'h1);
      if (((t - 1) % 60) >= 1) begin
        chk($sformatf("rot_lo_t%0d", t), 16'(loValue), 16'(k));
        chk($sformatf("rot_hi_t%0d", t), 16'(hiValue), 16'(10 + k));
      end
`endif
    end

    // Reset while requester 2 owns the display
    resetn = 1'b0;
    step();
    chk("midrst_gnt", 16'(gnt), 16'h0);
    chk("midrst_lo", 16'(loValue), 16'h0);
    chk("midrst_hi", 16'(hiValue), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h0);
    resetn = 1'b1; req = 4'b1100;
    step();
    chk("postrst_gnt", 16'(gnt), 16'h4);
    chk("postrst_busy", 16'(busy), 16'h1);

    // Requester 0 arrives while 2 is fresh in its hold window
    req = 4'b1101;
    step();
`ifdef SEG_SCHED_PRIORITY_EN
    chk("prio_gnt", 16'(gnt), 16'h1);
`else
    chk("noprio_gnt", 16'(gnt), 16'h4);
    chk("noprio_lo", 16'(loValue), 16'h2);
    chk("noprio_hi", 16'(hiValue), 16'hC);
    repeat (58) step();
    chk("noprio_t60_gnt", 16'(gnt), 16'h4);
    step();
    chk("noprio_t61_gnt", 16'(gnt), 16'h8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
